prio_burst_arbiter: RTL and testbench

Parametrised N-channel priority arbiter and output register that generalises the team's 8:1 priority mux. It selects one of N_CH valid/ready source channels by fixed priority or round-robin, locks the grant for a multi-beat burst, and drives the winner onto a registered valid/ready output. An `inactive` control forces the output to the idle value and stops new acceptances. It sits between the sprite/pixel or serial sources and the single downstream consumer.

---
 rtl/prio_burst_arbiter.sv | 146 ++++++++++++++
 tb/tb_prio_burst_arbiter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/prio_burst_arbiter.sv
// N-channel valid/ready arbiter with fixed-priority or round-robin selection,
// burst locking and a single registered output stage. The arbitration stage
// (p0) is purely combinational; the output register (p1) holds one beat.
module prio_burst_arbiter #(
    parameter int                N_CH     = 8,
    parameter int                DATA_W   = 1,
    parameter logic [DATA_W-1:0] IDLE_VAL = {DATA_W{1'b1}},
    parameter int                CH_W     = $clog2(N_CH)
) (
    input  logic                     Clk,
    input  logic                     Reset_n,
    input  logic [N_CH-1:0]          in_valid,
    input  logic [N_CH*DATA_W-1:0]   in_data,
    input  logic [N_CH-1:0]          in_last,
    output logic [N_CH-1:0]          in_ready,
    input  logic                     mode,
    input  logic                     inactive,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_last,
    output logic [CH_W-1:0]          out_ch,
    input  logic                     out_ready
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_BURST = 1'b1;

    logic [0:0]        state;
    logic [CH_W-1:0]   rr_ptr;
    logic [CH_W-1:0]   lock_ch;

    logic [N_CH-1:0]   low_mask_p0;
    logic [N_CH-1:0]   hi_vld_p0;
    logic [CH_W-1:0]   fp_idx_p0;
    logic [CH_W-1:0]   hi_idx_p0;
    logic [CH_W-1:0]   rr_idx_p0;
    logic [CH_W-1:0]   grant_p0;
    logic              grant_ok_p0;
    logic              space_p0;
    logic              accept_p0;
    logic [N_CH-1:0]   ready_p0;
    logic [DATA_W-1:0] sel_data_p0;
    logic              sel_last_p0;
    logic [CH_W-1:0]   next_ptr_p0;

    logic              vld_p1;
    logic [DATA_W-1:0] data_p1;
    logic              last_p1;
    logic [CH_W-1:0]   ch_p1;

    // ---- stage p0: arbitration ----
    // Channels below rr_ptr are masked off for the round-robin "at or after"
    // search; if none remain, the wrap-around winner is simply the lowest valid.
    assign low_mask_p0 = (N_CH'(1) << rr_ptr) - N_CH'(1);
    assign hi_vld_p0   = in_valid & ~low_mask_p0;

    // Lowest-index candidates for fixed priority and for the upper RR window
    always_comb begin
        fp_idx_p0 = '0;
        hi_idx_p0 = '0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            if (in_valid[k])  fp_idx_p0 = CH_W'(k);
            if (hi_vld_p0[k]) hi_idx_p0 = CH_W'(k);
        end
        rr_idx_p0 = (|hi_vld_p0) ? hi_idx_p0 : fp_idx_p0;
    end

    // Grant source: the locked channel during a burst, otherwise the arbiter
    always_comb begin
        if (state == ST_BURST) begin
            grant_p0    = lock_ch;
            grant_ok_p0 = in_valid[lock_ch];
        end else begin
            grant_p0    = mode ? rr_idx_p0 : fp_idx_p0;
            grant_ok_p0 = |in_valid;
        end
    end

    assign space_p0    = ~vld_p1 | out_ready;
    assign accept_p0   = space_p0 & ~inactive & grant_ok_p0;
    assign next_ptr_p0 = (grant_p0 == CH_W'(N_CH - 1)) ? '0 : grant_p0 + 1'b1;

    // One-hot accept strobe plus the granted channel's data and last flag
    always_comb begin
        ready_p0    = '0;
        sel_data_p0 = '0;
        sel_last_p0 = 1'b0;
        for (int k = 0; k < N_CH; k++) begin
            if (grant_p0 == CH_W'(k)) begin
                ready_p0[k] = accept_p0;
                sel_data_p0 = in_data[k*DATA_W +: DATA_W];
                sel_last_p0 = in_last[k];
            end
        end
    end

    // Reset also forces the strobe low while the flops are held cleared
    assign in_ready = ready_p0 & {N_CH{Reset_n}};

    // Burst FSM: lock on a non-last first beat, advance rr_ptr at burst end
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state   <= ST_IDLE;
            rr_ptr  <= '0;
            lock_ch <= '0;
        end else if (accept_p0) begin
            if (state == ST_IDLE) begin
                if (sel_last_p0) begin
                    rr_ptr <= next_ptr_p0;
                end else begin
                    state   <= ST_BURST;
                    lock_ch <= grant_p0;
                end
            end else if (sel_last_p0) begin
                state  <= ST_IDLE;
                rr_ptr <= next_ptr_p0;
            end
        end
    end

    // ---- stage p1: output register ----
    // Load on accept, otherwise fall back to the idle value once drained
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            vld_p1  <= 1'b0;
            data_p1 <= IDLE_VAL;
            last_p1 <= 1'b0;
            ch_p1   <= '0;
        end else if (accept_p0) begin
            vld_p1  <= 1'b1;
            data_p1 <= sel_data_p0;
            last_p1 <= sel_last_p0;
            ch_p1   <= grant_p0;
        end else if (vld_p1 && out_ready) begin
            vld_p1  <= 1'b0;
            data_p1 <= IDLE_VAL;
            last_p1 <= 1'b0;
        end
    end

    assign out_valid = vld_p1;
    assign out_data  = data_p1;
    assign out_last  = last_p1;
    assign out_ch    = ch_p1;

endmodule

// File: tb/tb_prio_burst_arbiter.sv
// Scoreboard bench for prio_burst_arbiter (8 channels, 4-bit data, idle 4'hF).
// A reference model predicts accept strobes and queues expected output beats;
// a separate monitor pops and compares whenever the output transfers.
module tb_prio_burst_arbiter;

    localparam int          N    = 8;
    localparam int          DW   = 4;
    localparam int          CW   = 3;
    localparam logic [3:0]  IDLE = 4'hF;

    logic            Clk = 1'b0;
    logic            Reset_n;
    logic [N-1:0]    in_valid;
    logic [N*DW-1:0] in_data;
    logic [N-1:0]    in_last;
    logic [N-1:0]    in_ready;
    logic            mode;
    logic            inactive;
    logic            out_valid;
    logic [DW-1:0]   out_data;
    logic            out_last;
    logic [CW-1:0]   out_ch;
    logic            out_ready;

    prio_burst_arbiter #(.N_CH(N), .DATA_W(DW), .IDLE_VAL(IDLE)) dut (
        .Clk(Clk), .Reset_n(Reset_n),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
        .mode(mode), .inactive(inactive),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ch(out_ch),
        .out_ready(out_ready)
    );

    always #5 Clk = ~Clk;

    typedef struct { int data; int last; int ch; } beat_t;
    beat_t sb_q[$];
    int    seen_ch[$];
    int    seen_data[$];
    int    n_chk  = 0;
    int    n_fail = 0;

    int rr_exp [5] = '{1, 3, 6, 1, 3};

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_seen(string nm, int idx, int ech, int ed);
        if (idx >= seen_ch.size()) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s[%0d]: no output beat, required ch %0d", nm, idx, ech);
        end else begin
            chk({nm, "_ch"}, 32'(seen_ch[idx]), 32'(ech));
            if (ed >= 0) chk({nm, "_data"}, 32'(seen_data[idx]), 32'(ed));
        end
    endtask

    // Reference model: abstract arbiter state and an "output slot occupied" flag
    int         m_burst, m_lock, m_rr, m_full, m_g;
    bit         m_ok, m_en, m_space;
    logic [2:0] m_gi;
    logic [7:0] m_er;
    beat_t      m_b;

    always @(negedge Clk) begin
        if (!Reset_n) begin
            m_burst = 0; m_lock = 0; m_rr = 0; m_full = 0;
            sb_q.delete();
            chk("rst_in_ready",  32'(in_ready),  32'(0));
            chk("rst_out_valid", 32'(out_valid), 32'(0));
            chk("rst_out_data",  32'(out_data),  32'(IDLE));
            chk("rst_out_last",  32'(out_last),  32'(0));
            chk("rst_out_ch",    32'(out_ch),    32'(0));
        end else begin
            m_space = (m_full == 0) || out_ready;
            m_ok = 0;
            m_g  = 0;
            if (m_burst != 0) begin
                m_g  = m_lock;
                m_gi = 3'(m_g);
                m_ok = in_valid[m_gi];
            end else if (!mode) begin
                for (int i = 0; i < N; i++)
                    if (!m_ok && ((in_valid >> i) & 8'h1) != 0) begin m_g = i; m_ok = 1; end
            end else begin
                for (int i = 0; i < N; i++)
                    if (!m_ok && ((in_valid >> ((m_rr + i) % N)) & 8'h1) != 0) begin
                        m_g = (m_rr + i) % N; m_ok = 1;
                    end
            end
            m_gi = 3'(m_g);
            m_en = m_space && !inactive && m_ok;
            m_er = m_en ? (8'h1 << m_gi) : 8'h0;
            chk("in_ready",  32'(in_ready),  32'(m_er));
            chk("out_valid", 32'(out_valid), 32'(m_full));
            if (m_en) begin
                m_b.data = int'((in_data >> (m_g * DW)) & 32'hF);
                m_b.last = int'(in_last[m_gi]);
                m_b.ch   = m_g;
                sb_q.push_back(m_b);
                if (m_b.last != 0) begin
                    m_burst = 0;
                    m_rr    = (m_g + 1) % N;
                end else begin
                    m_burst = 1;
                    m_lock  = m_g;
                end
            end
            m_full = m_en ? 1 : (out_ready ? 0 : m_full);
        end
    end

    // Monitor: output transfers, idle value and hold-under-backpressure
    bit            p_hold;
    logic [DW-1:0] p_data;
    logic          p_last;
    logic [CW-1:0] p_ch;
    beat_t         e;

    always @(negedge Clk) begin
        if (!Reset_n) begin
            p_hold = 0;
        end else begin
            if (p_hold) begin
                chk("hold_valid", 32'(out_valid), 32'(1));
                chk("hold_data",  32'(out_data),  32'(p_data));
                chk("hold_last",  32'(out_last),  32'(p_last));
                chk("hold_ch",    32'(out_ch),    32'(p_ch));
            end
            if (!out_valid) chk("idle_data", 32'(out_data), 32'(IDLE));
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL sb_underflow: output beat ch %0d data %0h with nothing expected", out_ch, out_data);
                end else begin
                    e = sb_q.pop_front();
                    chk("out_data", 32'(out_data), 32'(e.data));
                    chk("out_last", 32'(out_last), 32'(e.last));
                    chk("out_ch",   32'(out_ch),   32'(e.ch));
                end
                seen_ch.push_back(int'(out_ch));
                seen_data.push_back(int'(out_data));
            end
            p_hold = out_valid && !out_ready;
            p_data = out_data;
            p_last = out_last;
            p_ch   = out_ch;
        end
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive(logic [7:0] v, logic [7:0] l);
        in_valid = v;
        in_last  = l;
        in_data  = $urandom;
    endtask

    task automatic set_data(int ch, logic [3:0] val);
        in_data = (in_data & ~(32'hF << (ch * DW))) | (32'(val) << (ch * DW));
    endtask

    task automatic drain();
        in_valid = '0;
        step();
        step();
    endtask

    initial begin
        Reset_n = 1'b0; in_valid = '0; in_data = '0; in_last = '0;
        mode = 1'b0; inactive = 1'b0; out_ready = 1'b1;
        repeat (3) step();
        Reset_n = 1'b1;
        repeat (3) step();

        // Round-robin from rr_ptr=0 over channels 1,3,6
        seen_ch.delete(); seen_data.delete();
        mode = 1'b1;
        for (int i = 0; i < 5; i++) begin drive(8'b0100_1010, 8'hFF); step(); end
        drain();
        for (int i = 0; i < 5; i++) chk_seen("rr_seq", i, rr_exp[i], -1);

        // Fixed priority: ch2 beats ch5 and ch7 every cycle
        seen_ch.delete(); seen_data.delete();
        mode = 1'b0;
        for (int i = 0; i < 5; i++) begin drive(8'b1010_0100, 8'hFF); step(); end
        drain();
        for (int i = 0; i < 5; i++) chk_seen("fixed", i, 2, -1);

        // Burst lock on ch5 (rr_ptr=3) while ch0 stays valid
        seen_ch.delete(); seen_data.delete();
        mode = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(8'b0010_0001, (i == 3) ? 8'hFF : 8'h01);
            set_data(5, 4'(10 + i));
            step();
        end
        drive(8'b0110_0001, 8'hFF); step();
        drive(8'b0110_0001, 8'hFF); step();
        drain();
        for (int i = 0; i < 4; i++) chk_seen("burst", i, 5, 10 + i);
        chk_seen("burst_rr6", 4, 6, -1);
        chk_seen("burst_ch0", 5, 0, -1);

        // Backpressure mid-burst on ch4, then inactive, then resume
        seen_ch.delete(); seen_data.delete();
        mode = 1'b0;
        drive(8'b0001_0000, 8'h00); set_data(4, 4'h1); step();
        out_ready = 1'b0;
        drive(8'b0001_0000, 8'h00); set_data(4, 4'h2);
        repeat (3) step();
        out_ready = 1'b1; inactive = 1'b1;
        drive(8'b0001_0010, 8'h02); set_data(4, 4'h2);
        repeat (3) step();
        chk("inactive_idle", 32'(out_data), 32'(IDLE));
        inactive = 1'b0;
        step();
        drive(8'b0001_0010, 8'hFF); set_data(4, 4'h3); step();
        drive(8'b0001_0010, 8'hFF); step();
        drain();
        chk_seen("bp", 0, 4, 1);
        chk_seen("bp", 1, 4, 2);
        chk_seen("bp", 2, 4, 3);
        chk_seen("bp_after", 3, 1, -1);

        // Reset after the second of four beats on ch6
        mode = 1'b1;
        drive(8'b0100_0000, 8'h00); step();
        drive(8'b0100_0000, 8'h00); step();
        Reset_n = 1'b0;
        #1;
        chk("rst_drop_valid", 32'(out_valid), 32'(0));
        step();
        Reset_n = 1'b1;
        seen_ch.delete(); seen_data.delete();
        drive(8'b1100_0010, 8'hFF); step();
        drain();
        chk_seen("post_rst", 0, 1, -1);

        // Randomized traffic, including occasional reset pulses
        for (int c = 0; c < 2000; c++) begin
            drive(8'($urandom) & 8'($urandom), 8'($urandom));
            out_ready = ($urandom_range(0, 3) != 0);
            inactive  = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 19) == 0) mode = ~mode;
            if ($urandom_range(0, 299) == 0) begin
                Reset_n = 1'b0;
                step();
                Reset_n = 1'b1;
            end
            step();
        end
        inactive = 1'b0; out_ready = 1'b1;
        drain();
        chk("final_queue_empty", 32'(sb_q.size()), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
